mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Parametrised next-generation MEM pipeline stage plus MEM/WB register for the RISC-V 5-stage core.
- Replaces the fixed single-cycle word-only memory access with a request/acknowledge data-memory port of variable latency.
- Adds byte/halfword loads and stores with byte enables, sign and zero extension, and a pipeline stall and flush.
- Sits between EX/MEM and the writeback mux.

Parameters:
- ADDR_W, 32, data-memory byte-address width (dmem_addr width); ≤32.
- REG_AW, 5, register-index width.
- Data width is fixed at 32; byte lanes are fixed at 4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- valid_m  in  1  MEM-stage instruction valid.
- reg_write_m  in  1  register write enable.
- mem_read_m  in  1  load.
- mem_write_m  in  1  store (mem_read_m and mem_write_m both high is treated as store).
- result_src_m  in  2  00 ALU, 01 load data, 10 PC+4.
- funct3_m  in  3  access size/sign.
- rd_m  in  REG_AW  destination register.
- pc_plus4_m  in  32  PC+4.
- alu_result_m  in  32  effective address / ALU result.
- write_data_m  in  32  store data.
- flush_m  in  1  kill the instruction in MEM.
- stall_m  out  1  freeze IF..EX/MEM (combinational).
- dmem_req  out  1  request pulse.
- dmem_we  out  1  write.
- dmem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  access done; rdata valid this cycle.
- dmem_rdata  in  32  read word.
- valid_w, reg_write_w  out  1 each.
- result_src_w  out  2.
- rd_w  out  REG_AW.
- pc_plus4_w, alu_result_w, read_data_w  out  32 each.

Behaviour:
- Reset (synchronous): FSM goes to IDLE; all *_w outputs are 0; dmem_req is 0.
- Reset mid-WAIT: the FSM abandons the transaction; a later dmem_ack seen in IDLE is ignored.
- FSM states and transitions:
  - IDLE → WAIT when valid_m & (mem_read_m|mem_write_m) & !flush_m. dmem_req=1 for exactly this cycle; address, we, be and wdata are driven from the *_m inputs.
  - WAIT → IDLE on dmem_ack. dmem_req=0 while in WAIT.
- Ack timing: dmem_ack is never sampled in the request cycle, so the minimum load/store latency is 2 cycles.
- stall_m = (IDLE & mem op & !flush_m) | (WAIT & !dmem_ack).
- Upstream holds the EX/MEM inputs stable while stall_m is high.
- MEM/WB register, updated every edge:
  - When stall_m=1, it loads a bubble (valid_w=0, reg_write_w=0, other fields don't-care but held).
  - Otherwise it captures the *_m fields. reg_write_w = reg_write_m & valid_m & !killed.
  - read_data_w = aligned load result, captured on the ack cycle.
- Non-memory instructions pass with 1-cycle latency and no stall.
- Store alignment (off = alu_result_m[1:0]):
  - SB (000): be = 4'b0001<<off; wdata = byte replicated ×4.
  - SH (001): be = 4'b0011<<{off[1],0}; wdata = halfword replicated ×2.
  - SW (010): be = 4'b1111.
  - Other funct3 values are treated as SW.
- Load alignment:
  - LB / LBU extract byte lane off, with sign or zero extension.
  - LH / LHU extract halfword off[1], with sign or zero extension.
  - LW and undefined funct3 values return the whole word.
- Flush:
  - flush_m in IDLE: no request is issued; the next MEM/WB is a bubble.
  - flush_m in WAIT: the transaction still completes (no bus abort; stores are not cancellable). The instruction is marked killed and its writeback is suppressed (valid_w=0) on the ack edge.
  - The killed flag clears on return to IDLE.

Optional Feature:
- MISALIGN_TRAP_EN:
  - When defined, adds output misalign_w (1 bit, reset 0).
  - A misaligned LH/LHU/SH (off[0]=1) or LW/SW (off≠0) issues no request and causes no stall.
  - It passes in 1 cycle with valid_w=1, reg_write_w=0, misalign_w=1.
- When not defined: no port is added, and off[0] (halfword) or off[1:0] (word) are ignored, so the access is force-aligned.

Decomposition:
- Shared package mem_stage_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - result_src encodings RS_ALU, RS_MEM, RS_PC4;
  - FSM state enum {S_IDLE, S_WAIT}.
- One combinational sub-module, mem_lsu_align, converts (funct3, off, write data, read word) into (be, wdata, load result). The FSM and MEM/WB register stay in mem_stage_lsu.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, ack 1 cycle after req → be=1111, dmem_addr=0x100, stall_m high 1 cycle, reg_write_w=0.
- LB at 0x103, rdata 0x80FF_FF7F → read_data_w=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x000080FF.
- SB addr 0x101, data 0x000000AB → be=0010, wdata=0xABABABAB. SH addr 0x102 → be=1100.
- LW with ack delayed 5 cycles → stall_m high for 6 cycles, 6 bubbles in MEM/WB, then valid_w=1 with the data. A following ADD passes with 1-cycle latency.
- flush_m during WAIT of LW → valid_w=0 and reg_write_w=0 on the ack edge. flush_m in IDLE → dmem_req never asserted. rst during WAIT → all *_w=0 next cycle, and a late ack has no effect.
- (MISALIGN_TRAP_EN) LW at 0x102 → no dmem_req, misalign_w=1, reg_write_w=0, stall_m=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared constants, encodings and FSM state type for the MEM stage load/store unit.
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_e;

  // Access width in bytes; stores treat any non-B/H encoding as a word.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3, input logic is_store);
    logic [2:0] n;
    n = 3'd4;
    if (funct3 == F3_B || (!is_store && funct3 == F3_BU)) n = 3'd1;
    if (funct3 == F3_H || (!is_store && funct3 == F3_HU)) n = 3'd2;
    return n;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/acknowledge port between the MEM stage (master) and memory (slave).
interface mem_stage_lsu_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_lsu_align.sv
// Byte-lane steering: store byte enables / lane-replicated data, and load extract + extension.
module mem_lsu_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = store_data_i;
    case (funct3_i)
      F3_B: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      F3_H: begin
        be_o    = 4'b0011 << {off_i[1], 1'b0};
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (off_i)
      2'd0:    lane_byte = rdata_i[7:0];
      2'd1:    lane_byte = rdata_i[15:8];
      2'd2:    lane_byte = rdata_i[23:16];
      default: lane_byte = rdata_i[31:24];
    endcase
    lane_half = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    load_data_o = rdata_i;
    case (funct3_i)
      F3_B:    load_data_o = {{24{lane_byte[7]}}, lane_byte};
      F3_BU:   load_data_o = {24'b0, lane_byte};
      F3_H:    load_data_o = {{16{lane_half[15]}}, lane_half};
      F3_HU:   load_data_o = {16'b0, lane_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage with variable-latency data-memory port, stall/flush and MEM/WB register.
// Optional MISALIGN_TRAP_EN: flag misaligned H/W accesses instead of force-aligning them.
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_m,
  input  logic              reg_write_m,
  input  logic              mem_read_m,
  input  logic              mem_write_m,
  input  logic [1:0]        result_src_m,
  input  logic [2:0]        funct3_m,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [31:0]       pc_plus4_m,
  input  logic [31:0]       alu_result_m,
  input  logic [31:0]       write_data_m,
  input  logic              flush_m,
  output logic              stall_m,
  mem_stage_lsu_if.master   dmem,
`ifdef MISALIGN_TRAP_EN
  output logic              misalign_w,
`endif
  output logic              valid_w,
  output logic              reg_write_w,
  output logic [1:0]        result_src_w,
  output logic [REG_AW-1:0] rd_w,
  output logic [31:0]       pc_plus4_w,
  output logic [31:0]       alu_result_w,
  output logic [31:0]       read_data_w
);

  state_e      state_q, state_d;
  logic        killed_q, killed_d;
  logic        mem_op_raw, mem_op, misalign;
  logic        issue, kill, ack_done;
  logic [1:0]  off;
  logic [31:0] load_data;

  assign off        = alu_result_m[1:0];
  assign mem_op_raw = valid_m & (mem_read_m | mem_write_m);

`ifdef MISALIGN_TRAP_EN
  logic [2:0] nbytes;
  always_comb begin
    nbytes   = access_bytes(funct3_m, mem_write_m);
    misalign = 1'b0;
    if (nbytes == 3'd2) misalign = mem_op_raw & off[0];
    if (nbytes == 3'd4) misalign = mem_op_raw & (off != 2'b00);
  end
`else
  assign misalign = 1'b0;
`endif

  assign mem_op = mem_op_raw & ~misalign;

  mem_lsu_align u_align (
    .funct3_i     (funct3_m),
    .off_i        (off),
    .store_data_i (write_data_m),
    .rdata_i      (dmem.dmem_rdata),
    .be_o         (dmem.dmem_be),
    .wdata_o      (dmem.dmem_wdata),
    .load_data_o  (load_data)
  );

  assign dmem.dmem_req  = issue;
  assign dmem.dmem_we   = mem_write_m;
  assign dmem.dmem_addr = {alu_result_m[ADDR_W-1:2], 2'b00};

  always_comb begin
    state_d  = state_q;
    killed_d = killed_q;
    issue    = 1'b0;
    stall_m  = 1'b0;
    kill     = 1'b0;
    ack_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        kill = flush_m;
        if (mem_op && !flush_m) begin
          issue   = 1'b1;
          stall_m = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A flush here cannot abort the bus access; it only suppresses writeback.
        kill = killed_q | flush_m;
        if (dmem.dmem_ack) begin
          ack_done = 1'b1;
          killed_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          stall_m  = 1'b1;
          killed_d = kill;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      killed_q     <= 1'b0;
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      result_src_w <= '0;
      rd_w         <= '0;
      pc_plus4_w   <= '0;
      alu_result_w <= '0;
      read_data_w  <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_w   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      killed_q <= killed_d;
      if (stall_m) begin
        valid_w     <= 1'b0;
        reg_write_w <= 1'b0;
`ifdef MISALIGN_TRAP_EN
        misalign_w  <= 1'b0;
`endif
      end else begin
        valid_w      <= valid_m & ~kill;
        reg_write_w  <= reg_write_m & valid_m & ~kill & ~misalign;
        result_src_w <= result_src_m;
        rd_w         <= rd_m;
        pc_plus4_w   <= pc_plus4_m;
        alu_result_w <= alu_result_m;
`ifdef MISALIGN_TRAP_EN
        misalign_w   <= misalign & ~kill;
`endif
      end
      if (ack_done) read_data_w <= load_data;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed vector table, reset-in-WAIT sequence,
// and randomized operations checked against a byte-level reference model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_m, reg_write_m, mem_read_m, mem_write_m, flush_m;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [4:0]  rd_m;
  logic [31:0] pc_plus4_m, alu_result_m, write_data_m;
  logic        stall_m;
  logic        valid_w, reg_write_w;
  logic [1:0]  result_src_w;
  logic [4:0]  rd_w;
  logic [31:0] pc_plus4_w, alu_result_w, read_data_w;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_w;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] m_rd;  // model of read_data_w

  mem_stage_lsu_if #(.ADDR_W(32)) dmem_bus ();

  mem_stage_lsu #(.ADDR_W(32), .REG_AW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_m      (valid_m),
    .reg_write_m  (reg_write_m),
    .mem_read_m   (mem_read_m),
    .mem_write_m  (mem_write_m),
    .result_src_m (result_src_m),
    .funct3_m     (funct3_m),
    .rd_m         (rd_m),
    .pc_plus4_m   (pc_plus4_m),
    .alu_result_m (alu_result_m),
    .write_data_m (write_data_m),
    .flush_m      (flush_m),
    .stall_m      (stall_m),
    .dmem         (dmem_bus),
`ifdef MISALIGN_TRAP_EN
    .misalign_w   (misalign_w),
`endif
    .valid_w      (valid_w),
    .reg_write_w  (reg_write_w),
    .result_src_w (result_src_w),
    .rd_w         (rd_w),
    .pc_plus4_w   (pc_plus4_w),
    .alu_result_w (alu_result_w),
    .read_data_w  (read_data_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, rw, rd_op, wr_op;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] pc4, alu, wd, rdata;
    int          lat;       // cycles from request to ack (>= 1)
    int          flush_at;  // cycle index of a one-cycle flush pulse, -1 for none
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_load;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: byte-lane arithmetic straight from the access rules.
  function automatic int st_size(input logic [2:0] f3);
    return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
  endfunction

  function automatic int ld_size(input logic [2:0] f3);
    return (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
    int sz = st_size(f3);
    int a  = int'(off) - (int'(off) % sz);
    return 4'(((1 << sz) - 1) << a);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz = st_size(f3);
    if (sz == 1) return (wd & 32'h0000_00FF) * 32'h0101_0101;
    if (sz == 2) return (wd & 32'h0000_FFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] rdata);
    int sz = ld_size(f3);
    int a  = int'(off) - (int'(off) % sz);
    logic [31:0] v, mask;
    v = rdata >> (8 * a);
    if (sz == 4) return v;
    mask = 32'((64'd1 << (8 * sz)) - 64'd1);
    v = v & mask;
    if ((f3 == 3'b000 || f3 == 3'b001) && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic vec_t mkv(input logic valid, rw, rd_op, wr_op, input logic [1:0] rs,
                               input logic [2:0] f3, input logic [31:0] alu, wd, rdata,
                               input int lat, flush_at, input logic [3:0] exp_be,
                               input logic [31:0] exp_wdata, exp_load);
    vec_t v;
    v.valid = valid; v.rw = rw; v.rd_op = rd_op; v.wr_op = wr_op; v.rs = rs; v.f3 = f3;
    v.rd = 5'($urandom_range(1, 31)); v.pc4 = $urandom; v.alu = alu; v.wd = wd;
    v.rdata = rdata; v.lat = lat; v.flush_at = flush_at;
    v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_load = exp_load;
    return v;
  endfunction

  // Runs one instruction through MEM; entered and left at posedge+1.
  task automatic run_op(input vec_t v);
    logic issues = v.valid && (v.rd_op || v.wr_op) && (v.flush_at != 0);
    logic killed = 1'b0;
    logic exp_stall, ack;
    int   cyc = 0;
    bit   done = 0;
    valid_m = v.valid; reg_write_m = v.rw; mem_read_m = v.rd_op; mem_write_m = v.wr_op;
    result_src_m = v.rs; funct3_m = v.f3; rd_m = v.rd; pc_plus4_m = v.pc4;
    alu_result_m = v.alu; write_data_m = v.wd;
    while (!done) begin
      flush_m = (cyc == v.flush_at);
      if (cyc == v.flush_at) killed = 1'b1;
      ack = issues && (cyc == v.lat);
      dmem_bus.dmem_ack   = ack;
      dmem_bus.dmem_rdata = ack ? v.rdata : $urandom;
      exp_stall = issues && (cyc < v.lat);
      #2;
      chk("stall_m", stall_m, exp_stall);
      chk("dmem_req", dmem_bus.dmem_req, issues && cyc == 0);
      if (issues && cyc == 0) begin
        chk("dmem_addr", dmem_bus.dmem_addr, {v.alu[31:2], 2'b00});
        chk("dmem_we", dmem_bus.dmem_we, v.wr_op);
        if (v.wr_op) begin
          chk("dmem_be", dmem_bus.dmem_be, v.exp_be);
          chk("dmem_wdata", dmem_bus.dmem_wdata, v.exp_wdata);
        end
      end
      @(posedge clk); #1;
      if (exp_stall) begin
        chk("bubble valid_w", valid_w, 1'b0);
        chk("bubble reg_write_w", reg_write_w, 1'b0);
        cyc++;
        if (cyc > 200) begin
          chk("ack wait bound", 32'(cyc), 32'd200);
          done = 1;
        end
      end else begin
        if (ack) m_rd = v.exp_load;
        chk("valid_w", valid_w, v.valid && !killed);
        chk("reg_write_w", reg_write_w, v.rw && v.valid && !killed);
        chk("rd_w", rd_w, v.rd);
        chk("result_src_w", result_src_w, v.rs);
        chk("pc_plus4_w", pc_plus4_w, v.pc4);
        chk("alu_result_w", alu_result_w, v.alu);
        chk("read_data_w", read_data_w, m_rd);
        done = 1;
      end
    end
    flush_m = 1'b0;
    dmem_bus.dmem_ack = 1'b0;
  endtask

  task automatic set_add(input logic [31:0] a);
    valid_m = 1; reg_write_m = 1; mem_read_m = 0; mem_write_m = 0; result_src_m = 2'b00;
    funct3_m = 3'b000; rd_m = 5'd7; pc_plus4_m = 32'h44; alu_result_m = a; write_data_m = 0;
    flush_m = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    rst = 1; valid_m = 0; reg_write_m = 0; mem_read_m = 0; mem_write_m = 0; flush_m = 0;
    result_src_m = 0; funct3_m = 0; rd_m = 0; pc_plus4_m = 0; alu_result_m = 0;
    write_data_m = 0; dmem_bus.dmem_ack = 0; dmem_bus.dmem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid_w", valid_w, 1'b0);
    chk("rst reg_write_w", reg_write_w, 1'b0);
    chk("rst rd_w", rd_w, 5'd0);
    chk("rst pc_plus4_w", pc_plus4_w, 32'd0);
    chk("rst alu_result_w", alu_result_w, 32'd0);
    chk("rst read_data_w", read_data_w, 32'd0);
    chk("rst dmem_req", dmem_bus.dmem_req, 1'b0);
    rst = 0;
    m_rd = 32'd0;

    // valid, rw, rd, wr, rs, f3, alu, wd, rdata, lat, flush_at, be, wdata, load
    tbl.push_back(mkv(1, 0, 0, 1, 2'b00, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1, -1,
                      4'b1111, 32'hDEADBEEF, 32'h0));
    tbl.push_back(mkv(1, 1, 1, 0, 2'b01, 3'b000, 32'h103, 32'h0, 32'h80FFFF7F, 2, -1,
                      4'h0, 32'h0, 32'hFFFFFF80));
    tbl.push_back(mkv(1, 1, 1, 0, 2'b01, 3'b100, 32'h103, 32'h0, 32'h80FFFF7F, 1, -1,
                      4'h0, 32'h0, 32'h00000080));
    tbl.push_back(mkv(1, 1, 1, 0, 2'b01, 3'b101, 32'h102, 32'h0, 32'h80FFFF7F, 3, -1,
                      4'h0, 32'h0, 32'h000080FF));
    tbl.push_back(mkv(1, 0, 0, 1, 2'b00, 3'b000, 32'h101, 32'h000000AB, 32'h0, 1, -1,
                      4'b0010, 32'hABABABAB, 32'h0));
    tbl.push_back(mkv(1, 0, 0, 1, 2'b00, 3'b001, 32'h102, 32'h00001234, 32'h0, 2, -1,
                      4'b1100, 32'h12341234, 32'h0));
    tbl.push_back(mkv(1, 1, 1, 0, 2'b01, 3'b010, 32'h200, 32'h0, 32'h12345678, 6, -1,
                      4'h0, 32'h0, 32'h12345678));
    tbl.push_back(mkv(1, 1, 0, 0, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0, 1, -1,
                      4'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(1, 1, 1, 0, 2'b01, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 4, 2,
                      4'h0, 32'h0, 32'hCAFEF00D));
    tbl.push_back(mkv(1, 1, 1, 0, 2'b01, 3'b010, 32'h304, 32'h0, 32'h11111111, 2, 0,
                      4'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(1, 1, 1, 0, 2'b01, 3'b001, 32'h102, 32'h0, 32'h80010000, 1, -1,
                      4'h0, 32'h0, 32'hFFFF8001));
    tbl.push_back(mkv(1, 0, 0, 1, 2'b00, 3'b010, 32'h103, 32'h76543210, 32'h0, 1, -1,
                      4'b1111, 32'h76543210, 32'h0));
    tbl.push_back(mkv(1, 1, 1, 0, 2'b01, 3'b010, 32'h308, 32'h0, 32'h0BADBEEF, 2, 2,
                      4'h0, 32'h0, 32'h0BADBEEF));
    tbl.push_back(mkv(1, 1, 1, 1, 2'b00, 3'b000, 32'h10E, 32'h000000C3, 32'h0, 1, -1,
                      4'b0100, 32'hC3C3C3C3, 32'h0));
    foreach (tbl[i]) run_op(tbl[i]);

    // Reset while waiting for ack; the late ack must be ignored.
    v = mkv(1, 1, 1, 0, 2'b01, 3'b010, 32'h400, 32'h0, 32'h0, 9, -1, 4'h0, 32'h0, 32'h0);
    valid_m = 1; reg_write_m = 1; mem_read_m = 1; mem_write_m = 0; result_src_m = 2'b01;
    funct3_m = 3'b010; rd_m = v.rd; pc_plus4_m = v.pc4; alu_result_m = v.alu;
    #2;
    chk("rstwait req", dmem_bus.dmem_req, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    set_add(32'h99);
    @(posedge clk); #1;
    m_rd = 32'd0;
    chk("rstwait valid_w", valid_w, 1'b0);
    chk("rstwait reg_write_w", reg_write_w, 1'b0);
    chk("rstwait rd_w", rd_w, 5'd0);
    chk("rstwait read_data_w", read_data_w, 32'd0);
    rst = 0;
    dmem_bus.dmem_ack = 1; dmem_bus.dmem_rdata = 32'hFFFF_0000;
    #2;
    chk("late ack stall_m", stall_m, 1'b0);
    chk("late ack req", dmem_bus.dmem_req, 1'b0);
    @(posedge clk); #1;
    dmem_bus.dmem_ack = 0;
    chk("late ack valid_w", valid_w, 1'b1);
    chk("late ack alu_result_w", alu_result_w, 32'h99);
    chk("late ack read_data_w", read_data_w, 32'd0);

    // Randomized mix of loads, stores and ALU ops.
    for (int n = 0; n < 150; n++) begin
      int kind = $urandom_range(0, 9);
      logic [2:0] f3;
      logic [31:0] alu = $urandom;
      logic [31:0] wd = $urandom;
      logic [31:0] rdata = $urandom;
      int lat = $urandom_range(1, 4);
      int fa = ($urandom_range(0, 4) == 0) ? $urandom_range(0, lat) : -1;
      logic vld = ($urandom_range(0, 9) != 0);
      if (kind < 4) begin
        f3 = 3'($urandom_range(0, 7));
        v = mkv(vld, 1, 1, 0, 2'b01, f3, alu, wd, rdata, lat, fa,
                m_be(f3, alu[1:0]), m_wdata(f3, wd), m_load(f3, alu[1:0], rdata));
      end else if (kind < 7) begin
        f3 = 3'($urandom_range(0, 7));
        v = mkv(vld, 0, 1'($urandom_range(0, 1)), 1, 2'b00, f3, alu, wd, rdata, lat, fa,
                m_be(f3, alu[1:0]), m_wdata(f3, wd), m_load(f3, alu[1:0], rdata));
      end else begin
        f3 = 3'($urandom_range(0, 7));
        v = mkv(vld, 1'($urandom_range(0, 1)), 0, 0, ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00,
                f3, alu, wd, rdata, lat, fa, 4'h0, 32'h0, 32'h0);
      end
      run_op(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
